// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the multi-channel debouncer.
//   - deb_state_e    : per-channel FSM state (STABLE, PENDING)
//   - cnt_width()    : stability counter width for a given STABLE_CYCLES
//   - DEF_*          : default parameter values used by the modules
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 8;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;
  localparam int unsigned HOLD_W            = 32;

  // Counter only has to reach STABLE_CYCLES-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: single-bit debouncer.
//   2-flop synchroniser, STABLE/PENDING FSM with a stability counter,
//   registered level plus one-cycle rise/fall strobes. With the macro
//   DEBOUNCE_REPEAT_EN defined, also an auto-repeat strobe while held high.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sig_in       in   raw asynchronous input
//   sig_out      out  debounced level
//   rise_pulse   out  one-cycle strobe on sig_out 0->1
//   fall_pulse   out  one-cycle strobe on sig_out 1->0
//   repeat_pulse out  auto-repeat strobe (DEBOUNCE_REPEAT_EN only)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        INIT_LEVEL    = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef DEBOUNCE_REPEAT_EN
  ,
  output logic repeat_pulse
`endif
);

  localparam int unsigned   CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  deb_state_e    state;
  logic [CW-1:0] cnt;
  logic          commit_c;

  // Two-flop synchroniser; only s2 feeds the logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= INIT_LEVEL;
      s2 <= INIT_LEVEL;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

  // New value has held for the full window on this edge.
  assign commit_c = (state == PENDING) && (s2 != sig_out) && (cnt == CNT_LAST);

  // Stability FSM, counter and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE;
      cnt        <= '0;
      sig_out    <= INIT_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != sig_out) begin
            state <= PENDING;
            cnt   <= CNT_ONE;
          end
        end
        PENDING: begin
          if (s2 == sig_out) begin
            // Bounced back before the window elapsed.
            state <= STABLE;
            cnt   <= '0;
          end else if (commit_c) begin
            state      <= STABLE;
            cnt        <= '0;
            sig_out    <= s2;
            rise_pulse <= s2;
            fall_pulse <= ~s2;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [HOLD_W-1:0] DELAY_C  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] PERIOD_C = HOLD_W'(REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              first_done;
  logic [HOLD_W-1:0] hold_target_c;

  // First strobe waits the delay, later ones the period; counter reloads at each strobe.
  assign hold_target_c = first_done ? PERIOD_C : DELAY_C;

  // Auto-repeat while the debounced level stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      first_done   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (commit_c || !sig_out) begin
        // Restart on any edge; parked at zero while low.
        hold_cnt   <= '0;
        first_done <= 1'b0;
      end else if (hold_cnt + HOLD_ONE == hold_target_c) begin
        repeat_pulse <= 1'b1;
        hold_cnt     <= '0;
        first_done   <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end
`endif

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: CHANNELS independent debouncers with clean level and
// rise/fall strobes per channel. Defining the macro DEBOUNCE_REPEAT_EN adds
// the repeat_pulse port and per-channel auto-repeat hold counters.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sig_in       in   [CHANNELS] raw asynchronous inputs
//   sig_out      out  [CHANNELS] debounced levels
//   rise_pulse   out  [CHANNELS] one-cycle 0->1 strobes
//   fall_pulse   out  [CHANNELS] one-cycle 1->0 strobes
//   repeat_pulse out  [CHANNELS] auto-repeat strobes (DEBOUNCE_REPEAT_EN only)
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        INIT_LEVEL    = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
`ifdef DEBOUNCE_REPEAT_EN
  ,
  output logic [CHANNELS-1:0] repeat_pulse
`endif
);

  // One fully independent debouncer per channel.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_in       (sig_in[i]),
      .sig_out      (sig_out[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i])
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .repeat_pulse (repeat_pulse[i])
`endif
    );
  end

endmodule
